reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter sharing one WDT-wide D register among NREQ writers.
- Each winning requester's data is loaded into the register, and that requester gets a one-cycle ack pulse.
- The block sits in front of storage registers, so multiple producers can update a single state/config register without contention.
- Throughput: at most one write every 2 cycles.

Parameters:
- WDT, 4, register/data width in bits.
- NREQ, 4, number of requesters; legal range 2..16.
- RESET_VAL, 0, value of d_out after reset.
- IDW (localparam), $clog2(NREQ), width of requester index.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all state immediately when low.
- req  input  NREQ  per-requester write request; level, held until own ack seen.
- wdata  input  NREQ*WDT  packed write data; requester i occupies bits [i*WDT +: WDT].
- d_out  output  WDT  shared register contents.
- ack  output  NREQ  one-hot registered pulse; bit i high for exactly one cycle when i's write has landed.
- busy  output  1  high while arbiter is in HOLD.
- last_id  output  IDW  index of most recent winner.

Behaviour:
- Reset (rst_n low, async):
  - d_out=RESET_VAL, ack=0, busy=0, last_id=0.
  - Round-robin pointer ptr=0, state=IDLE.
- State IDLE:
  - If req==0, no change.
  - Else winner = first i with req[i]=1, searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1 (wrap-around).
  - At the edge: d_out<=wdata[winner], ack<=onehot(winner), last_id<=winner, ptr<=(winner+1) mod NREQ, busy<=1, state<=HOLD.
- State HOLD (exactly one cycle):
  - ack and busy are high, and d_out already holds the new value (latency req-to-d_out = 1 edge).
  - Requests are ignored.
  - Next edge: ack<=0, busy<=0, state<=IDLE.
- Requester protocol:
  - Hold req and wdata stable until ack[i] is sampled high; deassert req on that same edge.
  - A req still high in IDLE after its ack is treated as a new request.
- req dropped before ack: withdrawn, no write, no ack, ptr unchanged.
- wdata of non-winners is ignored; d_out changes only on a grant edge.
- Fairness: with all req continuously high, grants rotate 0,1,2,...,NREQ-1,0...; no requester waits more than NREQ grants.
- ptr wraps from NREQ-1 to 0.
- Reset mid-HOLD: ack clears asynchronously, the written value is lost (d_out=RESET_VAL), and ptr returns to 0.
- ack is never multi-hot; busy==|ack at all times.

Optional Feature:
- Macro: REG_WRITE_ARB_PRIO0_EN.
- When defined:
  - Requester 0 is urgent: if req[0]=1 in IDLE, it wins regardless of ptr.
  - ptr is NOT updated on a req[0] win.
  - Other requesters still arbitrate round-robin among themselves when req[0]=0.
- When undefined: requester 0 is an ordinary round-robin participant; pure round-robin as above.

Test Plan (WDT=4, NREQ=4, RESET_VAL=0):
1. Reset then single request: rst_n low 21ns, release; req=4'b0100, wdata slice2=4'h2 -> one edge later d_out=4'h2, ack=4'b0100 for one cycle, busy=1, last_id=2; drop req -> idle, d_out stays 4'h2.
2. All requesters continuous: req=4'b1111, slices 3..0 = 4'hD,C,B,A, each requester drops/re-raises per protocol -> grant order 0,1,2,3,0; d_out sequence A,B,C,D,A; one grant every 2 cycles.
3. Wrap-around: last_id=3, then req=4'b0011 -> winner 0 (not 1); next grant goes to 1.
4. Withdraw: req=4'b0010 raised and dropped while HOLD serves requester 3 -> no ack[1], d_out reflects only requester 3's data, ptr=0.
5. Reset mid-HOLD: assert rst_n low while ack=4'b0001 -> ack=0, busy=0, d_out=0 immediately; after release, req=4'b1010 -> winner 1.
6. With REG_WRITE_ARB_PRIO0_EN: ptr=2, req=4'b0101 -> winner 0 and ptr stays 2; next grant with req=4'b0100 -> winner 2. Without the macro, the same stimulus -> winner 2 first, then 0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one WDT-wide register among NREQ writers.
// Optional: define REG_WRITE_ARB_PRIO0_EN to make requester 0 urgent.
module reg_write_arbiter #(
    parameter int              WDT       = 4,
    parameter int              NREQ      = 4,
    parameter logic [WDT-1:0]  RESET_VAL = '0,
    localparam int             IDW       = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*WDT-1:0] wdata,
    output logic [WDT-1:0]      d_out,
    output logic [NREQ-1:0]     ack,
    output logic                busy,
    output logic [IDW-1:0]      last_id
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    localparam logic [IDW:0]    NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]  LAST_IX = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE     = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [WDT-1:0]  r_dout;
    logic [NREQ-1:0] r_ack;
    logic            r_busy;
    logic [IDW-1:0]  r_last;

    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW:0]    w_idx;
    logic [IDW-1:0]  w_nxt;
    logic [WDT-1:0]  w_wsel;
`ifdef REG_WRITE_ARB_PRIO0_EN
    logic            w_prio;
`endif

    // Search from r_ptr upward with wrap; first requester found wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= NREQ_W) begin
                w_idx = w_idx - NREQ_W;
            end
            if (!w_found && req[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDW-1:0];
            end
        end
`ifdef REG_WRITE_ARB_PRIO0_EN
        w_prio = req[0];
        if (req[0]) begin
            w_found = 1'b1;
            w_win   = '0;
        end
`endif
    end

    assign w_nxt  = (w_win == LAST_IX) ? '0 : w_win + IDW'(1);
    assign w_wsel = wdata[w_win*WDT +: WDT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_dout  <= RESET_VAL;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_last  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_dout  <= w_wsel;
                        r_ack   <= ONE << w_win;
                        r_last  <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= S_HOLD;
`ifdef REG_WRITE_ARB_PRIO0_EN
                        if (!w_prio) begin
                            r_ptr <= w_nxt;
                        end
`else
                        r_ptr   <= w_nxt;
`endif
                    end
                end
                S_HOLD: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign d_out   = r_dout;
    assign ack     = r_ack;
    assign busy    = r_busy;
    assign last_id = r_last;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed table-driven bench for reg_write_arbiter (WDT=4, NREQ=4).
module tb_reg_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  d_out;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  last_id;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter #(
        .WDT       (4),
        .NREQ      (4),
        .RESET_VAL (4'h0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wdata   (wdata),
        .d_out   (d_out),
        .ack     (ack),
        .busy    (busy),
        .last_id (last_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [15:0] wd;
        logic [3:0]  d;
        logic [3:0]  ack;
        logic        busy;
        logic [1:0]  last;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [3:0] q, logic [15:0] w,
                                logic [3:0] d, logic [3:0] a,
                                logic b, logic [1:0] l);
        vec_t v;
        v.rst = r; v.req = q; v.wd = w;
        v.d = d; v.ack = a; v.busy = b; v.last = l;
        return v;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, logic [3:0] d, logic [3:0] a,
                           logic b, logic [1:0] l);
        chk({tag, ".d_out"}, 16'(d_out), 16'(d));
        chk({tag, ".ack"}, 16'(ack), 16'(a));
        chk({tag, ".busy"}, 16'(busy), 16'(b));
        chk({tag, ".last_id"}, 16'(last_id), 16'(l));
    endtask

    task automatic do_reset(string tag);
        req   = '0;
        wdata = '0;
        rst_n = 1'b0;
        #21;
        chk_all(tag, 4'h0, 4'h0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(string tag, logic [3:0] q, logic [15:0] w,
                        logic [3:0] d, logic [3:0] a,
                        logic b, logic [1:0] l);
        @(negedge clk);
        req   = q;
        wdata = w;
        @(posedge clk);
        #1;
        chk_all(tag, d, a, b, l);
    endtask

    // Invariants sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!$onehot0(ack) || (busy !== (|ack))) begin
                errors++;
                $display("FAIL invariant: ack=%b busy=%b", ack, busy);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        wdata = '0;

        // single request, then idle
        vecs.push_back(mk(1, 4'b0000, 16'h0000, 4'h0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0100, 16'h0200, 4'h2, 4'b0100, 1, 2'd2));
        vecs.push_back(mk(0, 4'b0000, 16'h0200, 4'h2, 4'b0000, 0, 2'd2));
        vecs.push_back(mk(0, 4'b0000, 16'h0000, 4'h2, 4'b0000, 0, 2'd2));
        // all requesting: rotation 0,1,2,3,0
        vecs.push_back(mk(1, 4'b0000, 16'h0000, 4'h0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(0, 4'b1111, 16'hDCBA, 4'hA, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(0, 4'b1110, 16'hDCBA, 4'hA, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(0, 4'b1111, 16'hDCBA, 4'hB, 4'b0010, 1, 2'd1));
        vecs.push_back(mk(0, 4'b1101, 16'hDCBA, 4'hB, 4'b0000, 0, 2'd1));
        vecs.push_back(mk(0, 4'b1111, 16'hDCBA, 4'hC, 4'b0100, 1, 2'd2));
        vecs.push_back(mk(0, 4'b1011, 16'hDCBA, 4'hC, 4'b0000, 0, 2'd2));
        vecs.push_back(mk(0, 4'b1111, 16'hDCBA, 4'hD, 4'b1000, 1, 2'd3));
        vecs.push_back(mk(0, 4'b0111, 16'hDCBA, 4'hD, 4'b0000, 0, 2'd3));
        vecs.push_back(mk(0, 4'b1111, 16'hDCBA, 4'hA, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(0, 4'b1110, 16'hDCBA, 4'hA, 4'b0000, 0, 2'd0));
        // wrap-around after requester 3
        vecs.push_back(mk(1, 4'b0000, 16'h0000, 4'h0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(0, 4'b1000, 16'h9000, 4'h9, 4'b1000, 1, 2'd3));
        vecs.push_back(mk(0, 4'b0000, 16'h9000, 4'h9, 4'b0000, 0, 2'd3));
        vecs.push_back(mk(0, 4'b0011, 16'h0021, 4'h1, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(0, 4'b0010, 16'h0021, 4'h1, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0010, 16'h0021, 4'h2, 4'b0010, 1, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 16'h0021, 4'h2, 4'b0000, 0, 2'd1));
        // withdraw during HOLD
        vecs.push_back(mk(1, 4'b0000, 16'h0000, 4'h0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(0, 4'b1000, 16'h7000, 4'h7, 4'b1000, 1, 2'd3));
        vecs.push_back(mk(0, 4'b0010, 16'h7050, 4'h7, 4'b0000, 0, 2'd3));
        vecs.push_back(mk(0, 4'b0000, 16'h7050, 4'h7, 4'b0000, 0, 2'd3));
        vecs.push_back(mk(0, 4'b1010, 16'h7050, 4'h5, 4'b0010, 1, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 16'h7050, 4'h5, 4'b0000, 0, 2'd1));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (vecs[i].rst) begin
                do_reset(tag);
            end else begin
                step(tag, vecs[i].req, vecs[i].wd, vecs[i].d,
                     vecs[i].ack, vecs[i].busy, vecs[i].last);
            end
        end

        // reset while HOLD serves requester 0
        do_reset("mh.rst0");
        step("mh.grant", 4'b0001, 16'h0003, 4'h3, 4'b0001, 1'b1, 2'd0);
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk_all("mh.async", 4'h0, 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("mh.after", 4'b1010, 16'h6040, 4'h4, 4'b0010, 1'b1, 2'd1);
        step("mh.idle", 4'b0000, 16'h6040, 4'h4, 4'b0000, 1'b0, 2'd1);

        // ptr=2, then requesters 0 and 2 together
        do_reset("pr.rst");
        step("pr.setup", 4'b0010, 16'h0050, 4'h5, 4'b0010, 1'b1, 2'd1);
        step("pr.idle", 4'b0000, 16'h0050, 4'h5, 4'b0000, 1'b0, 2'd1);
`ifdef REG_WRITE_ARB_PRIO0_EN
        step("pr.g0", 4'b0101, 16'h0803, 4'h3, 4'b0001, 1'b1, 2'd0);
        step("pr.h0", 4'b0100, 16'h0803, 4'h3, 4'b0000, 1'b0, 2'd0);
        step("pr.g1", 4'b0100, 16'h0803, 4'h8, 4'b0100, 1'b1, 2'd2);
`else
        step("pr.g0", 4'b0101, 16'h0803, 4'h8, 4'b0100, 1'b1, 2'd2);
        step("pr.h0", 4'b0001, 16'h0803, 4'h8, 4'b0000, 1'b0, 2'd2);
        step("pr.g1", 4'b0001, 16'h0803, 4'h3, 4'b0001, 1'b1, 2'd0);
`endif
        step("pr.end", 4'b0000, 16'h0803, d_out, 4'b0000, 1'b0, last_id);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
